// File: rtl/seq_divider_pkg.sv
// Shared ALU constants for the sequential divider: datapath width, FSM encoding
// and the two's-complement minimum used by the signed-overflow case.
package seq_divider_pkg;

  localparam int DIV_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic [DIV_W-1:0] SIGNED_MIN = 16'h8000;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, try to
// subtract the divisor, keep the difference only when it does not borrow.
module seq_divider_div_step #(
  parameter int L = 16
) (
  input  logic [L:0]   p_in,
  input  logic         dvd_bit,
  input  logic [L-1:0] divisor,
  output logic [L:0]   p_out,
  output logic         q_bit
);

  logic [L+1:0] shifted;
  logic [L+1:0] trial;

  // p_in stays below the divisor, so the top bit of the shifted value is zero
  // and trial[L+1] is a clean borrow flag.
  always_comb begin
    shifted = {p_in, dvd_bit};
    trial   = shifted - {2'b00, divisor};
    q_bit   = ~trial[L+1];
    p_out   = q_bit ? trial[L:0] : shifted[L:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle L-bit divider, one quotient bit per cycle, with RISC-V style
// results for divide-by-zero and signed overflow.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int L = DIV_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [L-1:0] Dividend,
  input  logic [L-1:0] Divisor,
  input  logic         Signed,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [L-1:0] Quotient,
  output logic [L-1:0] Remainder,
  output logic         DivByZero,
  output logic         Overflow
);

  localparam int          CW      = $clog2(L);
  localparam logic [CW-1:0] CNT_MAX = CW'(L - 1);
  localparam logic [L-1:0]  MIN_NEG = {1'b1, {(L-1){1'b0}}};

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [L-1:0]  dvd_q, dvd_d;
  logic [L-1:0]  dvs_q, dvs_d;
  logic [L:0]    p_q, p_d;
  logic [L-1:0]  quo_q, quo_d;
  logic          neg_q_q, neg_q_d;
  logic          neg_r_q, neg_r_d;
  logic [L-1:0]  quotient_q, quotient_d;
  logic [L-1:0]  remainder_q, remainder_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;
  logic          out_valid_q, out_valid_d;

  logic [L:0]    step_p;
  logic          step_q;
  logic [L-1:0]  quo_next;
  logic          sgn_dvd, sgn_dvs;
  logic [L-1:0]  mag_dvd, mag_dvs;
  logic          is_zero, is_ovf;

  seq_divider_div_step #(.L(L)) u_step (
    .p_in    (p_q),
    .dvd_bit (dvd_q[L-1]),
    .divisor (dvs_q),
    .p_out   (step_p),
    .q_bit   (step_q)
  );

  // 0x8000 negates to itself, which is also its correct unsigned magnitude.
  always_comb begin
    sgn_dvd = Signed & Dividend[L-1];
    sgn_dvs = Signed & Divisor[L-1];
    mag_dvd = sgn_dvd ? ({L{1'b0}} - Dividend) : Dividend;
    mag_dvs = sgn_dvs ? ({L{1'b0}} - Divisor) : Divisor;
    is_zero = (Divisor == '0);
    is_ovf  = Signed & (Dividend == MIN_NEG) & (Divisor == '1);
    quo_next = {quo_q[L-2:0], step_q};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    p_d         = p_q;
    quo_d       = quo_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (InValid) begin
          neg_q_d = sgn_dvd ^ sgn_dvs;
          neg_r_d = sgn_dvd;
          dvd_d   = mag_dvd;
          dvs_d   = mag_dvs;
          p_d     = '0;
          quo_d   = '0;
          cnt_d   = CNT_MAX;
          dbz_d   = is_zero;
          ovf_d   = is_ovf;
          if (is_zero) begin
            quotient_d  = '1;
            remainder_d = Dividend;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else if (is_ovf) begin
            quotient_d  = MIN_NEG;
            remainder_d = '0;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        p_d   = step_p;
        quo_d = quo_next;
        dvd_d = dvd_q << 1;
        if (cnt_q == '0) begin
          quotient_d  = neg_q_q ? ({L{1'b0}} - quo_next) : quo_next;
          remainder_d = neg_r_q ? ({L{1'b0}} - step_p[L-1:0]) : step_p[L-1:0];
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (OutReady) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      p_q         <= '0;
      quo_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      p_q         <= p_d;
      quo_q       <= quo_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign InReady   = (state_q == ST_IDLE);
  assign OutValid  = out_valid_q;
  assign Quotient  = quotient_q;
  assign Remainder = remainder_q;
  assign DivByZero = dbz_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a reference model fills a scoreboard at
// operand accept, results are popped and compared when OutValid appears.
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int L = DIV_W;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         InValid;
  logic         InReady;
  logic [L-1:0] Dividend;
  logic [L-1:0] Divisor;
  logic         Signed;
  logic         OutValid;
  logic         OutReady;
  logic [L-1:0] Quotient;
  logic [L-1:0] Remainder;
  logic         DivByZero;
  logic         Overflow;

  typedef struct {
    logic [L-1:0] q;
    logic [L-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t scb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_divider #(.L(L)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .InValid   (InValid),
    .InReady   (InReady),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Signed    (Signed),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero),
    .Overflow  (Overflow)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [L-1:0] a, input logic [L-1:0] b, input logic s);
    exp_t e;
    logic signed [L-1:0] sa;
    logic signed [L-1:0] sb;
    sa    = a;
    sb    = b;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = L + 1;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
      e.lat = 1;
    end else if (s && a == SIGNED_MIN && b == '1) begin
      e.q   = SIGNED_MIN;
      e.r   = '0;
      e.ovf = 1'b1;
      e.lat = 1;
    end else if (s) begin
      e.q = sa / sb;
      e.r = sa % sb;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run(input logic [L-1:0] a, input logic [L-1:0] b, input logic s,
                     input int hold, input string tag);
    exp_t e;
    int   lat;
    check({tag, ":in_ready_idle"}, 32'(InReady), 32'(1));
    Dividend = a;
    Divisor  = b;
    Signed   = s;
    InValid  = 1'b1;
    scb.push_back(model(a, b, s));
    tick();
    InValid  = 1'b0;
    Dividend = L'($urandom);
    Divisor  = L'($urandom);
    Signed   = ~s;
    check({tag, ":in_ready_busy"}, 32'(InReady), 32'(0));
    lat = 1;
    while (!OutValid && lat < 40) begin
      InValid = (lat < 10);
      tick();
      lat++;
    end
    InValid = 1'b0;
    e = scb.pop_front();
    check({tag, ":latency"}, 32'(lat), 32'(e.lat));
    check({tag, ":quotient"}, 32'(Quotient), 32'(e.q));
    check({tag, ":remainder"}, 32'(Remainder), 32'(e.r));
    check({tag, ":div_by_zero"}, 32'(DivByZero), 32'(e.dbz));
    check({tag, ":overflow"}, 32'(Overflow), 32'(e.ovf));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ":hold_valid"}, 32'(OutValid), 32'(1));
      check({tag, ":hold_quotient"}, 32'(Quotient), 32'(e.q));
      check({tag, ":hold_remainder"}, 32'(Remainder), 32'(e.r));
      check({tag, ":hold_in_ready"}, 32'(InReady), 32'(0));
    end
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    check({tag, ":post_valid"}, 32'(OutValid), 32'(0));
    check({tag, ":post_in_ready"}, 32'(InReady), 32'(1));
  endtask

  initial begin
    Reset    = 1'b1;
    InValid  = 1'b0;
    OutReady = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    Signed   = 1'b0;
    tick();
    tick();
    check("rst_quotient", 32'(Quotient), 32'(0));
    check("rst_remainder", 32'(Remainder), 32'(0));
    check("rst_valid", 32'(OutValid), 32'(0));
    check("rst_dbz", 32'(DivByZero), 32'(0));
    check("rst_ovf", 32'(Overflow), 32'(0));
    check("rst_in_ready", 32'(InReady), 32'(1));
    Reset = 1'b0;
    tick();

    run(16'd100,  16'd7,    1'b0, 0, "u100_7");
    run(16'hFFF9, 16'h0002, 1'b1, 0, "s_m7_2");
    run(16'h0007, 16'hFFFE, 1'b1, 0, "s_7_m2");
    run(16'd1234, 16'd0,    1'b0, 0, "u_dbz");
    run(16'd1234, 16'd0,    1'b1, 0, "s_dbz");
    run(16'h8000, 16'hFFFF, 1'b1, 0, "s_ovf");
    run(16'h8000, 16'hFFFF, 1'b0, 0, "u_min_m1");
    run(16'hFFFF, 16'h0001, 1'b0, 0, "u_max_1");
    run(16'd100,  16'd7,    1'b0, 5, "backpressure");
    for (int i = 0; i < 6; i++) begin
      run(L'($urandom), L'($urandom_range(1, 65535)), i[0], 0, "rnd");
    end

    // Abort a long division part-way with an asynchronous reset.
    Dividend = 16'hFFFF;
    Divisor  = 16'h0003;
    Signed   = 1'b0;
    InValid  = 1'b1;
    tick();
    InValid = 1'b0;
    repeat (8) tick();
    #2;
    Reset = 1'b1;
    #1;
    check("mid_rst_quotient", 32'(Quotient), 32'(0));
    check("mid_rst_remainder", 32'(Remainder), 32'(0));
    check("mid_rst_valid", 32'(OutValid), 32'(0));
    check("mid_rst_dbz", 32'(DivByZero), 32'(0));
    check("mid_rst_ovf", 32'(Overflow), 32'(0));
    check("mid_rst_in_ready", 32'(InReady), 32'(1));
    tick();
    Reset = 1'b0;
    tick();
    run(16'd9, 16'd3, 1'b0, 0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
